// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic ops, iterative shifts/multiply.
// Optional iterative multiplier on opcode 1011 when ALU_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       OPC4,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Aout,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             Err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [3:0]       opc;
    logic [WIDTH-1:0] sh;
    logic [SHW:0]     cnt;

    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   wide;
    logic             c, v, err, go_busy;
    logic [SHW-1:0]   s;
    logic [WIDTH-1:0] sh_nx;
    logic             c_nx;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mh, ma, mh_nx;
    logic [WIDTH:0]   sum;
`endif

    assign s = Bin[SHW-1:0];

    always_comb begin
        res = '0;
        wide = '0;
        c = 1'b0;
        v = 1'b0;
        err = 1'b0;
        go_busy = 1'b0;
        unique case (OPC4)
            4'b0000: res = Bin;
            4'b0001: begin
                wide = {1'b0, Ain} + {1'b0, Bin};
                res = wide[WIDTH-1:0];
                c = wide[WIDTH];
                v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
            end
            4'b0010: begin
                wide = {1'b0, Ain} - {1'b0, Bin};
                res = wide[WIDTH-1:0];
                c = wide[WIDTH];
                v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
            end
            4'b0011: res = Ain;
            4'b0100: res = '0;
            4'b0101: res = Ain & Bin;
            4'b0110: res = Ain | Bin;
            4'b0111: res = ~Ain;
            4'b1000, 4'b1001, 4'b1010: begin
                res = Ain;
                go_busy = (s != '0);
            end
`ifdef ALU_MUL_EN
            4'b1011: go_busy = 1'b1;
`endif
            default: err = 1'b1;
        endcase
    end

    // One bit (or one shift-add step) per BUSY cycle
    always_comb begin
        sh_nx = sh;
        c_nx = 1'b0;
`ifdef ALU_MUL_EN
        sum = '0;
        mh_nx = mh;
`endif
        unique case (opc)
            4'b1000: begin
                sh_nx = sh << 1;
                c_nx = sh[WIDTH-1];
            end
            4'b1001: begin
                sh_nx = sh >> 1;
                c_nx = sh[0];
            end
            4'b1010: begin
                sh_nx = {sh[WIDTH-1], sh[WIDTH-1:1]};
                c_nx = sh[0];
            end
`ifdef ALU_MUL_EN
            4'b1011: begin
                sum = {1'b0, mh} + (sh[0] ? {1'b0, ma} : '0);
                mh_nx = sum[WIDTH:1];
                sh_nx = {sum[0], sh[WIDTH-1:1]};
                c_nx = |sum[WIDTH:1];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            opc <= '0;
            sh <= '0;
            cnt <= '0;
            Aout <= '0;
            Cout <= 1'b0;
            V <= 1'b0;
            Z <= 1'b1;
            N <= 1'b0;
            Err <= 1'b0;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
`ifdef ALU_MUL_EN
            mh <= '0;
            ma <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    opc <= OPC4;
                    in_ready <= 1'b0;
                    sh <= (OPC4 == 4'b1011) ? Bin : Ain;
                    cnt <= (OPC4 == 4'b1011) ? (SHW+1)'(WIDTH) : {1'b0, s};
`ifdef ALU_MUL_EN
                    mh <= '0;
                    ma <= Ain;
`endif
                    if (go_busy) begin
                        state <= BUSY;
                    end else begin
                        state <= DONE;
                        out_valid <= 1'b1;
                        Aout <= res;
                        Cout <= c;
                        V <= v;
                        Z <= (res == '0);
                        N <= res[WIDTH-1];
                        Err <= err;
                    end
                end
                BUSY: begin
                    sh <= sh_nx;
                    cnt <= cnt - 1'b1;
`ifdef ALU_MUL_EN
                    mh <= mh_nx;
`endif
                    if (cnt == 1) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                        Aout <= sh_nx;
                        Cout <= c_nx;
                        V <= 1'b0;
                        Z <= (sh_nx == '0);
                        N <= sh_nx[WIDTH-1];
                        Err <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8).
// Covers both ALU_MUL_EN builds via the same macro.
module tb_alu_seq;

    logic       Clk = 0;
    logic       Rst_n;
    logic       in_valid, in_ready;
    logic [3:0] OPC4;
    logic [7:0] Ain, Bin;
    logic       out_valid, out_ready;
    logic [7:0] Aout;
    logic       Cout, V, Z, N, Err;

    int total = 0;
    int bad = 0;

    alu_seq #(.WIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .OPC4(OPC4), .Ain(Ain), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .Aout(Aout), .Cout(Cout), .V(V), .Z(Z), .N(N), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Flags packed as {Cout,V,Z,N,Err}
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge Clk);
        in_valid = 1;
        OPC4 = op;
        Ain = a;
        Bin = b;
        @(posedge Clk);
        #1;
        in_valid = 0;
        Ain = 8'hA5;
        Bin = 8'h5A;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff(input string tag);
        @(negedge Clk);
        out_ready = 1;
        @(posedge Clk);
        #1;
        out_ready = 0;
        chk({tag, ".ird"}, {31'd0, in_ready}, 1);
    endtask

    task automatic op_chk(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] ea, input logic [4:0] ef,
                          input int el);
        int lat;
        issue(op, a, b, lat);
        chk({tag, ".lat"}, lat, el);
        chk({tag, ".res"}, {24'd0, Aout}, {24'd0, ea});
        chk({tag, ".flg"}, {27'd0, Cout, V, Z, N, Err}, {27'd0, ef});
        handoff(tag);
    endtask

    initial begin
        int lat;
        Rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        OPC4 = 0;
        Ain = 0;
        Bin = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.res", {24'd0, Aout}, 0);
        chk("rst.flg", {27'd0, Cout, V, Z, N, Err}, 5'b00100);
        chk("rst.ov", {31'd0, out_valid}, 0);
        chk("rst.ird", {31'd0, in_ready}, 1);
        @(negedge Clk);
        Rst_n = 1;

        op_chk("add_ovf", 4'b0001, 8'h7F, 8'h01, 8'h80, 5'b01010, 1);
        op_chk("sub_brw", 4'b0010, 8'h03, 8'h05, 8'hFE, 5'b10010, 1);
        op_chk("add_wrap", 4'b0001, 8'hFF, 8'h01, 8'h00, 5'b10100, 1);
        op_chk("sub_ovf", 4'b0010, 8'h80, 8'h01, 8'h7F, 5'b01000, 1);
        op_chk("load", 4'b0000, 8'h33, 8'h00, 8'h00, 5'b00100, 1);
        op_chk("pass", 4'b0011, 8'h33, 8'hFF, 8'h33, 5'b00000, 1);
        op_chk("clr", 4'b0100, 8'hFF, 8'hFF, 8'h00, 5'b00100, 1);
        op_chk("and", 4'b0101, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1);
        op_chk("or", 4'b0110, 8'hF0, 8'h0F, 8'hFF, 5'b00010, 1);
        op_chk("not", 4'b0111, 8'h0F, 8'h00, 8'hF0, 5'b00010, 1);
        op_chk("sar2", 4'b1010, 8'h90, 8'h02, 8'hE4, 5'b00010, 3);
        op_chk("shr1", 4'b1001, 8'h81, 8'h01, 8'h40, 5'b10000, 2);
        op_chk("shl0", 4'b1000, 8'h5A, 8'h00, 8'h5A, 5'b00000, 1);
        op_chk("shl7", 4'b1000, 8'h81, 8'h07, 8'h80, 5'b00010, 8);
        op_chk("sar7", 4'b1010, 8'h80, 8'h07, 8'hFF, 5'b00010, 8);
        op_chk("ill_c", 4'b1100, 8'h12, 8'h34, 8'h00, 5'b00101, 1);
        op_chk("ill_f", 4'b1111, 8'hFF, 8'hFF, 8'h00, 5'b00101, 1);
`ifdef ALU_MUL_EN
        op_chk("mul_ov", 4'b1011, 8'h10, 8'h11, 8'h10, 5'b10000, 9);
        op_chk("mul", 4'b1011, 8'h0F, 8'h03, 8'h2D, 5'b00000, 9);
`else
        op_chk("mul_ill", 4'b1011, 8'h10, 8'h11, 8'h00, 5'b00101, 1);
`endif

        // Backpressure: result held while new requests are refused
        issue(4'b0001, 8'h7F, 8'h01, lat);
        chk("bp.lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            in_valid = 1;
            OPC4 = 4'b0100;
            Ain = 8'h00;
            @(posedge Clk);
            #1;
            chk("bp.ov", {31'd0, out_valid}, 1);
            chk("bp.ird", {31'd0, in_ready}, 0);
            chk("bp.res", {24'd0, Aout}, 8'h80);
            chk("bp.flg", {27'd0, Cout, V, Z, N, Err}, 5'b01010);
        end
        @(negedge Clk);
        in_valid = 0;
        handoff("bp");
        chk("bp.ovlo", {31'd0, out_valid}, 0);
        op_chk("bp.next", 4'b0011, 8'h2D, 8'h00, 8'h2D, 5'b00000, 1);

        // Async reset while an iterative op is in flight
        @(negedge Clk);
        in_valid = 1;
        OPC4 = 4'b1010;
        Ain = 8'h80;
        Bin = 8'h07;
        @(posedge Clk);
        #1;
        in_valid = 0;
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 0;
        #1;
        chk("arst.ov", {31'd0, out_valid}, 0);
        chk("arst.res", {24'd0, Aout}, 0);
        chk("arst.z", {31'd0, Z}, 1);
        @(negedge Clk);
        Rst_n = 1;
        #1;
        chk("arst.ird", {31'd0, in_ready}, 1);
        op_chk("arst.next", 4'b0001, 8'h01, 8'h02, 8'h03, 5'b00000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 4-bit clocked ALU.
- Operand width is set by a parameter.
- Adds variable-distance iterative shifts, an iterative multiply, a full flag set and valid/ready flow control.
- Sits between the datapath controller, which issues operations, and the accumulator/register-file write-back, which consumes results.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width, taken from Bin[SHW-1:0]; derived, do not override.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- OPC4  input  4  opcode.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B / shift amount.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- Aout  output  WIDTH  registered result.
- Cout  output  1  carry/borrow/shift-out/mul-overflow.
- V  output  1  signed overflow.
- Z  output  1  result is zero.
- N  output  1  result MSB.
- Err  output  1  illegal opcode executed.

Behaviour:
- Reset (async, Rst_n=0): state IDLE, Aout=0, Cout=V=N=Err=0, Z=1, out_valid=0, in_ready=1. Reset takes effect immediately, mid-operation included; any in-flight op is discarded.
- States IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid=1, latch OPC4/Ain/Bin at the edge. Later operand changes are ignored.
  - Single-cycle ops go to DONE with the result registered. out_valid is high 1 cycle after accept.
  - Shift with amount 0 goes directly to DONE, result = A, Cout=0.
  - Shift with amount s>0 goes to BUSY with counter=s. MUL goes to BUSY with counter=WIDTH.
- BUSY: one shift bit or one shift-add step per cycle; the counter decrements. When the counter reaches 0, go to DONE.
  - Latency: shifts 1+s cycles; MUL 1+WIDTH cycles.
- DONE: hold Aout and all flags stable until out_ready=1, then go to IDLE. No new op is accepted until the cycle after handoff.
  - Max throughput is one op per 2 cycles.
- Opcodes:
  - 0000 LOAD: B.
  - 0001 ADD: A+B.
  - 0010 SUB: A-B.
  - 0011 PASS: A.
  - 0100 CLR: 0.
  - 0101 AND.
  - 0110 OR.
  - 0111 NOT A.
  - 1000 SHL by s.
  - 1001 SHR by s (logical).
  - 1010 SAR by s (arithmetic).
  - 1011 MUL: low WIDTH bits of unsigned A*B.
  - 1100-1111 illegal.
- Cout:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (A<B unsigned).
  - Shifts: last bit shifted out.
  - MUL: 1 if the upper WIDTH product bits are non-zero.
  - All other ops: 0.
- V: signed two's-complement overflow for ADD/SUB; 0 for all other ops.
- Z = (result==0). N = result[WIDTH-1].
- All flags are registered together with Aout and update only on entry to DONE.
- Illegal opcode: single-cycle, Aout=0, Err=1, Cout=V=N=0, Z=1. Err=0 for every legal op.
- Wrap-around: ADD/SUB/MUL results are truncated modulo 2^WIDTH.

Optional Feature:
- ALU_MUL_EN defined: opcode 1011 executes the iterative multiply as above.
- ALU_MUL_EN undefined: no multiplier logic; 1011 is treated as illegal (Err=1, Aout=0, single-cycle).

Test Plan:
- WIDTH=8, ADD 0x7F+0x01 -> Aout=0x80, V=1, N=1, Cout=0, Z=0; out_valid 1 cycle after accept.
- SUB 0x03-0x05 -> Aout=0xFE, Cout=1, N=1, V=0. Then ADD 0xFF+0x01 -> Aout=0x00, Cout=1, Z=1.
- Shifts:
  - SAR A=0x90, B=2 -> Aout=0xE4, Cout=0, out_valid 3 cycles after accept.
  - SHR A=0x81, B=1 -> Aout=0x40, Cout=1.
  - SHL B=0 -> Aout=A, latency 1.
- MUL (ALU_MUL_EN):
  - 0x10*0x11 -> Aout=0x10, Cout=1, latency 9.
  - 0x0F*0x03 -> Aout=0x2D, Cout=0.
  - Without the macro, opcode 1011 -> Err=1, Aout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> Aout/flags/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Reset and illegal opcode:
  - Assert Rst_n=0 mid-MUL (BUSY) -> out_valid=0, Aout=0, Z=1 immediately; after release, in_ready=1.
  - Opcode 1100 -> Err=1, Z=1.
